// File: rtl/lt24_rect_scheduler_if.sv
// Request and LT24 pixel bus bundle for lt24_rect_scheduler.
// Ports: req0_*/req1_* carry rectangle commands with valid/ready; busy/done* report status;
//   xAddr/yAddr/pixelData/pixelWrite/pixelReady form the LT24Display pixel handshake.
//   master = scheduler view, slave = requester/display view.
interface lt24_rect_scheduler_if #(
  parameter int XW = 8,
  parameter int YW = 9
);
  logic          req0_valid;
  logic          req0_ready;
  logic [XW-1:0] req0_x0;
  logic [XW-1:0] req0_x1;
  logic [YW-1:0] req0_y0;
  logic [YW-1:0] req0_y1;
  logic [15:0]   req0_colour;

  logic          req1_valid;
  logic          req1_ready;
  logic [XW-1:0] req1_x0;
  logic [XW-1:0] req1_x1;
  logic [YW-1:0] req1_y0;
  logic [YW-1:0] req1_y1;
  logic [15:0]   req1_colour;

  logic          busy;
  logic          done;
  logic          done_id;
  logic          done_err;

  logic [XW-1:0] xAddr;
  logic [YW-1:0] yAddr;
  logic [15:0]   pixelData;
  logic          pixelWrite;
  logic          pixelReady;

  modport master (
    input  req0_valid, req0_x0, req0_x1, req0_y0, req0_y1, req0_colour,
    input  req1_valid, req1_x0, req1_x1, req1_y0, req1_y1, req1_colour,
    input  pixelReady,
    output req0_ready, req1_ready,
    output busy, done, done_id, done_err,
    output xAddr, yAddr, pixelData, pixelWrite
  );

  modport slave (
    output req0_valid, req0_x0, req0_x1, req0_y0, req0_y1, req0_colour,
    output req1_valid, req1_x0, req1_x1, req1_y0, req1_y1, req1_colour,
    output pixelReady,
    input  req0_ready, req1_ready,
    input  busy, done, done_id, done_err,
    input  xAddr, yAddr, pixelData, pixelWrite
  );
endinterface

// File: rtl/lt24_rect_scheduler.sv
// Two-port round-robin rectangle-fill scheduler driving the LT24Display pixel interface.
// Latency: accept at T, first pixel T+2, done one cycle after the last handshake.
// Backpressure: one command in flight; pixel outputs hold while pixelReady=0; ready only in IDLE.
// Ports: clock, reset_n (synchronous, active-low), bus (lt24_rect_scheduler_if.master).
module lt24_rect_scheduler #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int XW     = 8,
  parameter int YW     = 9
) (
  input  logic                         clock,
  input  logic                         reset_n,
  lt24_rect_scheduler_if.master        bus
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FILL, S_DONE} state_t;

  // Largest on-panel coordinate; "> MAX" is "≥ size" without overflowing XW/YW.
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;       // port favoured when both are valid
  logic          owner_q, owner_d;
  logic          err_q, err_d;
  logic [XW-1:0] cx0_q, cx0_d, cx1_q, cx1_d;
  logic [YW-1:0] cy0_q, cy0_d, cy1_q, cy1_d;
  logic [15:0]   ccol_q, ccol_d;     // colour as captured at accept
  logic [XW-1:0] xa_q, xa_d, xb_q, xb_d;
  logic [YW-1:0] yb_q, yb_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   pdat_q, pdat_d;     // colour on the pixel bus; only changes entering FILL

  logic          any_vld, win1, idle_ok, hs, last_col;
  logic [XW-1:0] xa_c, xb_c;
  logic [YW-1:0] ya_c, yb_c;
  logic          off_panel;

  always_comb begin
    any_vld = bus.req0_valid | bus.req1_valid;
    win1    = bus.req1_valid & (~bus.req0_valid | ptr_q);
    // Ready is suppressed while reset_n is low so no command is offered during reset.
    idle_ok = (state_q == S_IDLE) & reset_n;

    xa_c = (cx0_q < cx1_q) ? cx0_q : cx1_q;
    xb_c = (cx0_q < cx1_q) ? cx1_q : cx0_q;
    ya_c = (cy0_q < cy1_q) ? cy0_q : cy1_q;
    yb_c = (cy0_q < cy1_q) ? cy1_q : cy0_q;
    off_panel = (xa_c > X_MAX) | (ya_c > Y_MAX);

    hs       = (state_q == S_FILL) & bus.pixelReady;
    last_col = (x_q == xb_q);
  end

  assign bus.req0_ready = idle_ok & any_vld & ~win1;
  assign bus.req1_ready = idle_ok & win1;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.done_id    = (state_q == S_DONE) & owner_q;
  assign bus.done_err   = (state_q == S_DONE) & err_q;
  assign bus.pixelWrite = (state_q == S_FILL);
  assign bus.xAddr      = x_q;
  assign bus.yAddr      = y_q;
  assign bus.pixelData  = pdat_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    err_d   = err_q;
    cx0_d   = cx0_q;
    cx1_d   = cx1_q;
    cy0_d   = cy0_q;
    cy1_d   = cy1_q;
    ccol_d  = ccol_q;
    xa_d    = xa_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    x_d     = x_q;
    y_d     = y_q;
    pdat_d  = pdat_q;

    case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          owner_d = win1;
          ptr_d   = ~win1;
          cx0_d   = win1 ? bus.req1_x0     : bus.req0_x0;
          cx1_d   = win1 ? bus.req1_x1     : bus.req0_x1;
          cy0_d   = win1 ? bus.req1_y0     : bus.req0_y0;
          cy1_d   = win1 ? bus.req1_y1     : bus.req0_y1;
          ccol_d  = win1 ? bus.req1_colour : bus.req0_colour;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d = off_panel;
        if (off_panel) begin
          state_d = S_DONE;
        end else begin
          xa_d    = xa_c;
          xb_d    = (xb_c > X_MAX) ? X_MAX : xb_c;
          yb_d    = (yb_c > Y_MAX) ? Y_MAX : yb_c;
          x_d     = xa_c;
          y_d     = ya_c;
          pdat_d  = ccol_q;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (hs) begin
          // The final pixel leaves x/y untouched so the bus holds the last address.
          if (last_col && (y_q == yb_q)) begin
            state_d = S_DONE;
          end else if (last_col) begin
            x_d = xa_q;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      cx0_q   <= '0;
      cx1_q   <= '0;
      cy0_q   <= '0;
      cy1_q   <= '0;
      ccol_q  <= '0;
      xa_q    <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pdat_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      cx0_q   <= cx0_d;
      cx1_q   <= cx1_d;
      cy0_q   <= cy0_d;
      cy1_q   <= cy1_d;
      ccol_q  <= ccol_d;
      xa_q    <= xa_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pdat_q  <= pdat_d;
    end
  end

endmodule

// File: doc/lt24_rect_scheduler.md
# lt24_rect_scheduler

Two-port rectangle-fill scheduler that owns the LT24Display pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady). It accepts solid-colour rectangle commands from two requesters, such as a background painter and a brick/sprite painter. It arbitrates between them round-robin, normalises and clips each rectangle to the panel, and rasters it row-major into the display one pixel per accepted handshake. It sits between game-state logic and LT24Display, replacing free-running x/y counters.

## Interface

- WIDTH, 240, panel width in pixels
- HEIGHT, 320, panel height in pixels
- XW, 8, x coordinate width
- YW, 9, y coordinate width

- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- reqN_valid  in  1  port N (N=0,1) command valid
- reqN_ready  out  1  port N command accepted when valid&&ready
- reqN_x0, reqN_x1  in  XW  port N x corners (any order)
- reqN_y0, reqN_y1  in  YW  port N y corners (any order)
- reqN_colour  in  16  port N RGB565 fill colour
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of each command
- done_id  out  1  port that owned the finished command; valid with done
- done_err  out  1  command rejected (off-panel); valid with done
- xAddr  out  XW  pixel x to LT24Display
- yAddr  out  YW  pixel y to LT24Display
- pixelData  out  16  pixel colour to LT24Display
- pixelWrite  out  1  pixel request to LT24Display
- pixelReady  in  1  LT24Display ready; pixel consumed on edge where pixelWrite&&pixelReady

## Operation

- States: IDLE, CHECK, FILL, DONE.
- IDLE:
  - Winner = the valid port. If both are valid, the winner is the port the priority pointer selects.
  - reqN_ready = (state==IDLE) && winner==N, combinational. Never high for both ports.
  - On acceptance, capture the command and owner id, flip the pointer to the other port, and go to CHECK.
- CHECK, one cycle:
  - Normalise: xa=min(x0,x1), xb=max(x0,x1); same for y.
  - If xa>=WIDTH or ya>=HEIGHT, set err and go to DONE with zero pixel writes.
  - Otherwise clip xb to min(xb,WIDTH-1) and yb to min(yb,HEIGHT-1), load x=xa, y=ya, and go to FILL.
- FILL:
  - Drive pixelWrite=1, xAddr=x, yAddr=y, pixelData=colour.
  - On each handshake: if x==xb, set x=xa and y=y+1; otherwise x=x+1.
  - A handshake at x==xb && y==yb goes to DONE.
  - Outputs stay stable while pixelReady=0.
- DONE, one cycle: done=1 with done_id and done_err, then go to IDLE.
- Arithmetic: compare in XW/YW unsigned. Coordinates never wrap, because clipping guarantees xb<=WIDTH-1 and yb<=HEIGHT-1.
- pixelWrite=0 in every state except FILL. xAddr/yAddr/pixelData hold their last value outside FILL.
- Commands are not pre-empted. A request on the other port waits until IDLE.

## Timing

- Reset value of every output is 0. Registered state = IDLE, pointer = port 0.
  - reqN_ready is 0 during reset and becomes active the first cycle after release.
- Accept at edge T:
  - CHECK during T+1.
  - First pixel presented (pixelWrite=1) during T+2.
- With pixelReady held high, throughput is 1 pixel/cycle. Rectangle of P pixels: last handshake at edge T+1+P.
- Last pixel handshake at edge M: done high during M+1, IDLE (ready possible) during M+2.
- Rejected command accepted at edge T: done/done_err high during T+2, IDLE at T+3.
- Back-to-back commands: minimum 3 non-writing cycles between the last pixel of one command and the first pixel of the next.
- reset_n low mid-FILL:
  - All outputs are 0 the cycle after the edge.
  - The in-flight command is discarded with no done.
  - The pointer returns to port 0.

## Test plan

- Single command: req0 (10,20)-(12,21), colour F800, pixelReady=1. Expected: exactly 6 writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done one cycle after last; done_id=0, done_err=0.
- Contention: both ports valid from reset, each with a 1-pixel rect, held valid. Expected grants 0,1,0,1. Never both ready in one cycle.
- Stall: 4-pixel rect with pixelReady toggling 1,0,0,1,… Expected: address and data stable across stalls, exactly 4 distinct handshakes, none skipped or repeated.
- Normalise/clip/reject:
  - (239,319)-(230,318) gives 20 writes, x 230..239 and y 318..319.
  - (235,0)-(250,0) gives 5 writes, x 235..239.
  - x0=240,x1=245 gives zero pixelWrite cycles and done_err=1.
- Single pixel: req1 (0,0)-(0,0) accepted at T. Expected: pixelWrite high during T+2 only, done during T+3, done_id=1.
- Reset mid-fill: reset_n low for one cycle during a 100-pixel fill. Expected: outputs 0 next cycle and no done. A new req0 afterwards fills from its first pixel.
